// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide memory port between m0 (cpu core) and
// m1 (loader/debug). Writes are posted into a 1-entry buffer per port and are
// drained ahead of that port's later reads. Reads are granted round-robin.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   mN_addr/data_in/write_en    port N request (write_en is a 1-cycle pulse)
//   mN_read_en                  port N read request (level)
//   mN_data_out/ready           port N read data, valid with the 1-cycle ready pulse
//   mem_addr/data_in/write_en   memory write side
//   mem_read_en/data_out/ready  memory read handshake
//   grant                       one-hot owner of the current memory op (0 when idle)
//   wr_overflow                 sticky per-port dropped-write flag
//   timeout                     sticky aborted-read flag
module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_data_in,
  input  logic              m0_write_en,
  input  logic              m0_read_en,
  output logic [DATA_W-1:0] m0_data_out,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_data_in,
  input  logic              m1_write_en,
  input  logic              m1_read_en,
  output logic [DATA_W-1:0] m1_data_out,
  output logic              m1_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_ready,
  output logic [1:0]        grant,
  output logic [1:0]        wr_overflow,
  output logic              timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_RELEASE} state_t;

  state_t                   state, state_nxt;
  logic [1:0][ADDR_W-1:0]   req_addr, wbuf_addr, wbuf_addr_nxt;
  logic [1:0][DATA_W-1:0]   req_data, wbuf_data, wbuf_data_nxt, rdata, rdata_nxt;
  logic [1:0]               req_rd, req_wr, elig, wv, wv_nxt, rdy, rdy_nxt;
  logic [1:0]               grant_nxt, wr_overflow_nxt;
  logic                     last_grant, last_grant_nxt, owner, owner_nxt;
  logic                     req_lost, req_lost_nxt, win, lost;
  logic [CNT_W-1:0]         tcnt, tcnt_nxt;
  logic [ADDR_W-1:0]        mem_addr_nxt;
  logic [DATA_W-1:0]        mem_data_in_nxt;
  logic                     mem_write_en_nxt, mem_read_en_nxt, timeout_nxt;

  assign req_addr    = {m1_addr, m0_addr};
  assign req_data    = {m1_data_in, m0_data_in};
  assign req_rd      = {m1_read_en, m0_read_en};
  assign req_wr      = {m1_write_en, m0_write_en};
  assign elig        = wv | req_rd;
  assign m0_data_out = rdata[0];
  assign m1_data_out = rdata[1];
  assign m0_ready    = rdy[0];
  assign m1_ready    = rdy[1];

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      wbuf_addr    <= '0;
      wbuf_data    <= '0;
      wv           <= '0;
      rdata        <= '0;
      rdy          <= '0;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      req_lost     <= 1'b0;
      tcnt         <= '0;
      grant        <= '0;
      wr_overflow  <= '0;
      timeout      <= 1'b0;
      mem_addr     <= '0;
      mem_data_in  <= '0;
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;
    end else begin
      state        <= state_nxt;
      wbuf_addr    <= wbuf_addr_nxt;
      wbuf_data    <= wbuf_data_nxt;
      wv           <= wv_nxt;
      rdata        <= rdata_nxt;
      rdy          <= rdy_nxt;
      last_grant   <= last_grant_nxt;
      owner        <= owner_nxt;
      req_lost     <= req_lost_nxt;
      tcnt         <= tcnt_nxt;
      grant        <= grant_nxt;
      wr_overflow  <= wr_overflow_nxt;
      timeout      <= timeout_nxt;
      mem_addr     <= mem_addr_nxt;
      mem_data_in  <= mem_data_in_nxt;
      mem_write_en <= mem_write_en_nxt;
      mem_read_en  <= mem_read_en_nxt;
    end
  end

  // Write capture, arbitration and memory handshake
  always_comb begin
    state_nxt        = state;
    wbuf_addr_nxt    = wbuf_addr;
    wbuf_data_nxt    = wbuf_data;
    wv_nxt           = wv;
    rdata_nxt        = rdata;
    rdy_nxt          = '0;
    last_grant_nxt   = last_grant;
    owner_nxt        = owner;
    req_lost_nxt     = req_lost;
    tcnt_nxt         = tcnt;
    grant_nxt        = grant;
    wr_overflow_nxt  = wr_overflow;
    timeout_nxt      = timeout;
    mem_addr_nxt     = mem_addr;
    mem_data_in_nxt  = mem_data_in;
    mem_write_en_nxt = 1'b0;
    mem_read_en_nxt  = mem_read_en;
    win              = 1'b0;
    lost             = 1'b0;

    // A full buffer only accepts a new write in the cycle it drains
    for (int n = 0; n < 2; n++) begin
      if (req_wr[n]) begin
        if (wv[n] && !(state == ST_WRITE && owner == 1'(n))) begin
          wr_overflow_nxt[n] = 1'b1;
        end else begin
          wbuf_addr_nxt[n] = req_addr[n];
          wbuf_data_nxt[n] = req_data[n];
          wv_nxt[n]        = 1'b1;
        end
      end else if (state == ST_WRITE && owner == 1'(n)) begin
        wv_nxt[n] = 1'b0;
      end
    end

    case (state)
      ST_IDLE: begin
        if (|elig) begin
          win             = elig[!last_grant] ? !last_grant : last_grant;
          owner_nxt       = win;
          last_grant_nxt  = win;
          grant_nxt       = win ? 2'b10 : 2'b01;
          mem_data_in_nxt = wbuf_data[win];
          tcnt_nxt        = '0;
          req_lost_nxt    = 1'b0;
          // A pending posted write always goes before that port's read
          if (wv[win]) begin
            mem_addr_nxt     = wbuf_addr[win];
            mem_write_en_nxt = 1'b1;
            state_nxt        = ST_WRITE;
          end else begin
            mem_addr_nxt     = req_addr[win];
            mem_read_en_nxt  = 1'b1;
            state_nxt        = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        grant_nxt = '0;
        state_nxt = ST_IDLE;
      end
      ST_READ: begin
        if (tcnt < CNT_W'(TIMEOUT_CYCLES)) tcnt_nxt = tcnt + CNT_W'(1);
        // Once the requester lets go, the data of this op is discarded
        lost         = req_lost | ~req_rd[owner];
        req_lost_nxt = lost;
        if (mem_ready) begin
          if (!lost) begin
            rdata_nxt[owner] = mem_data_out;
            rdy_nxt[owner]   = 1'b1;
          end
          mem_read_en_nxt = 1'b0;
          state_nxt       = ST_RELEASE;
        end else if (tcnt >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
          if (!lost) begin
            rdata_nxt[owner] = '0;
            rdy_nxt[owner]   = 1'b1;
          end
          timeout_nxt     = 1'b1;
          mem_read_en_nxt = 1'b0;
          grant_nxt       = '0;
          state_nxt       = ST_IDLE;
        end
      end
      ST_RELEASE: begin
        if (tcnt < CNT_W'(TIMEOUT_CYCLES)) tcnt_nxt = tcnt + CNT_W'(1);
        if (!mem_ready) begin
          grant_nxt = '0;
          state_nxt = ST_IDLE;
        end else if (tcnt >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_nxt = 1'b1;
          grant_nxt   = '0;
          state_nxt   = ST_IDLE;
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a small byte memory model.
// Unwritten memory locations read back as addr[7:0] ^ 8'h7A.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_addr, m1_addr, mem_addr;
  logic [7:0]  m0_data_in, m1_data_in, m0_data_out, m1_data_out;
  logic        m0_write_en, m0_read_en, m0_ready;
  logic        m1_write_en, m1_read_en, m1_ready;
  logic [7:0]  mem_data_in, mem_data_out;
  logic        mem_write_en, mem_read_en, mem_ready;
  logic [1:0]  grant, wr_overflow;
  logic        timeout;
  logic        stall;

  int errors = 0;
  int checks = 0;

  bit [7:0] store [256];
  bit       written [256];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(8), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_data_in(m0_data_in), .m0_write_en(m0_write_en),
    .m0_read_en(m0_read_en), .m0_data_out(m0_data_out), .m0_ready(m0_ready),
    .m1_addr(m1_addr), .m1_data_in(m1_data_in), .m1_write_en(m1_write_en),
    .m1_read_en(m1_read_en), .m1_data_out(m1_data_out), .m1_ready(m1_ready),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_data_out(mem_data_out), .mem_ready(mem_ready),
    .grant(grant), .wr_overflow(wr_overflow), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Memory model: ready one cycle after read_en (unless stalled), drops one cycle after it
  always @(posedge clk) begin
    mem_ready    <= mem_read_en & ~stall;
    mem_data_out <= written[mem_addr[7:0]] ? store[mem_addr[7:0]] : (mem_addr[7:0] ^ 8'h7A);
    if (mem_write_en) begin
      store[mem_addr[7:0]]   <= mem_data_in;
      written[mem_addr[7:0]] <= 1'b1;
    end
  end

  task automatic test_reset();
    bit found;
    found = 1'b0;
    rst = 1'b1; stall = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_data_in = '0; m1_data_in = '0;
    m0_write_en = 1'b0; m1_write_en = 1'b0; m0_read_en = 1'b0; m1_read_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
    checks++; if (mem_read_en !== 1'b0 || mem_write_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got rd=%b wr=%b expected 0 0", mem_read_en, mem_write_en); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b expected 00", m1_ready, m0_ready); end
    checks++; if (m0_data_out !== 8'h00 || m1_data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h %h expected 00 00", m0_data_out, m1_data_out); end
    checks++; if (wr_overflow !== 2'b00 || timeout !== 1'b0) begin errors++; $display("FAIL reset_sticky: got ovf=%b to=%b expected 00 0", wr_overflow, timeout); end
    // Start a stalled read, then reset in the middle of it
    rst = 1'b0; stall = 1'b1; m0_addr = 32'h20; m0_read_en = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_read_en) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL reset_midread_start: got no mem_read_en expected mem_read_en=1"); end
    #1 rst = 1'b1;
    #1;
    checks++; if (mem_read_en !== 1'b0) begin errors++; $display("FAIL reset_async_rd: got %b expected 0", mem_read_en); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_async_grant: got %b expected 00", grant); end
    m0_read_en = 1'b0; stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] g [4];
    logic [1:0] prev;
    int ng, c0, c1;
    logic [7:0] d0, d1;
    ng = 0; c0 = 0; c1 = 0; prev = 2'b00; d0 = '0; d1 = '0;
    for (int k = 0; k < 4; k++) g[k] = 2'b00;
    m0_addr = 32'h20; m1_addr = 32'h21; m0_read_en = 1'b1; m1_read_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (grant != 2'b00 && prev == 2'b00) begin
        if (ng < 4) g[ng] = grant;
        ng++;
        if (ng == 3) m1_read_en = 1'b0;
      end
      prev = grant;
      if (m0_ready) begin c0++; d0 = m0_data_out; if (c0 == 2) m0_read_en = 1'b0; end
      if (m1_ready) begin c1++; d1 = m1_data_out; end
    end
    checks++; if (ng != 3) begin errors++; $display("FAIL rr_grant_count: got %0d expected 3", ng); end
    checks++; if (g[0] !== 2'b01) begin errors++; $display("FAIL rr_grant0_tie: got %b expected 01", g[0]); end
    checks++; if (g[1] !== 2'b10) begin errors++; $display("FAIL rr_grant1: got %b expected 10", g[1]); end
    checks++; if (g[2] !== 2'b01) begin errors++; $display("FAIL rr_grant2: got %b expected 01", g[2]); end
    checks++; if (c0 != 2) begin errors++; $display("FAIL rr_m0_pulses: got %0d expected 2", c0); end
    checks++; if (c1 != 1) begin errors++; $display("FAIL rr_m1_pulses: got %0d expected 1", c1); end
    checks++; if (d0 !== 8'h5A) begin errors++; $display("FAIL rr_m0_data: got %h expected 5a", d0); end
    checks++; if (d1 !== 8'h5B) begin errors++; $display("FAIL rr_m1_data: got %h expected 5b", d1); end
  endtask

  task automatic test_write_then_read();
    int wcyc, rcyc, c0;
    logic [31:0] waddr;
    logic [7:0]  wdata, d0;
    wcyc = -1; rcyc = -1; c0 = 0; waddr = '0; wdata = '0; d0 = '0;
    m0_addr = 32'hAA; m0_data_in = 8'h05; m0_write_en = 1'b1;
    @(negedge clk);
    m0_write_en = 1'b0; m0_read_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_write_en && wcyc < 0) begin wcyc = i; waddr = mem_addr; wdata = mem_data_in; end
      if (mem_read_en && rcyc < 0) rcyc = i;
      if (m0_ready) begin c0++; d0 = m0_data_out; m0_read_en = 1'b0; end
    end
    checks++; if (wcyc < 0) begin errors++; $display("FAIL wr_rd_write_seen: got none expected one mem_write_en"); end
    checks++; if (rcyc <= wcyc) begin errors++; $display("FAIL wr_rd_order: got rd@%0d wr@%0d expected rd after wr", rcyc, wcyc); end
    checks++; if (waddr !== 32'hAA || wdata !== 8'h05) begin errors++; $display("FAIL wr_rd_payload: got %h/%h expected aa/05", waddr, wdata); end
    checks++; if (c0 != 1) begin errors++; $display("FAIL wr_rd_pulses: got %0d expected 1", c0); end
    checks++; if (d0 !== 8'h05) begin errors++; $display("FAIL wr_rd_data: got %h expected 05", d0); end
  endtask

  task automatic test_overflow();
    bit found;
    int nw, c1;
    logic [31:0] wa;
    logic [7:0]  wd, d1;
    found = 1'b0; nw = 0; c1 = 0; wa = '0; wd = '0; d1 = '0;
    stall = 1'b1; m1_addr = 32'h30; m1_read_en = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (grant == 2'b10) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL ovf_m1_grant: got %b expected 10", grant); end
    m0_addr = 32'h40; m0_data_in = 8'h10; m0_write_en = 1'b1;
    @(negedge clk);
    m0_addr = 32'h41; m0_data_in = 8'h11;
    @(negedge clk);
    m0_write_en = 1'b0;
    checks++; if (wr_overflow !== 2'b01) begin errors++; $display("FAIL ovf_flag: got %b expected 01", wr_overflow); end
    stall = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_write_en) begin nw++; wa = mem_addr; wd = mem_data_in; end
      if (m1_ready) begin c1++; d1 = m1_data_out; m1_read_en = 1'b0; end
    end
    checks++; if (nw != 1) begin errors++; $display("FAIL ovf_write_count: got %0d expected 1", nw); end
    checks++; if (wa !== 32'h40 || wd !== 8'h10) begin errors++; $display("FAIL ovf_write_payload: got %h/%h expected 40/10", wa, wd); end
    checks++; if (c1 != 1 || d1 !== 8'h4A) begin errors++; $display("FAIL ovf_m1_read: got n=%0d d=%h expected n=1 d=4a", c1, d1); end
    checks++; if (wr_overflow !== 2'b01) begin errors++; $display("FAIL ovf_sticky: got %b expected 01", wr_overflow); end
  endtask

  task automatic test_abandon();
    bit found;
    int c0, nr;
    found = 1'b0; c0 = 0; nr = 0;
    stall = 1'b1; m0_addr = 32'h20; m0_read_en = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (grant == 2'b01) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL abandon_grant: got %b expected 01", grant); end
    @(negedge clk);
    @(negedge clk);
    m0_read_en = 1'b0; stall = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m0_ready) c0++;
      if (mem_ready) nr++;
    end
    checks++; if (c0 != 0) begin errors++; $display("FAIL abandon_no_ready: got %0d expected 0", c0); end
    checks++; if (nr < 1) begin errors++; $display("FAIL abandon_mem_done: got %0d ready cycles expected >=1", nr); end
    checks++; if (grant !== 2'b00 || mem_read_en !== 1'b0) begin errors++; $display("FAIL abandon_idle: got grant=%b rd=%b expected 00 0", grant, mem_read_en); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL abandon_timeout: got %b expected 0", timeout); end
  endtask

  task automatic test_timeout();
    bit found;
    int early;
    found = 1'b0; early = 0;
    stall = 1'b1; m0_addr = 32'h20; m0_read_en = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (grant == 2'b01) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL to_grant: got %b expected 01", grant); end
    // First READ cycle now; m1 queues behind the stalled read
    m1_addr = 32'h21; m1_read_en = 1'b1;
    if (timeout !== 1'b0) early++;
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      if (timeout !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL to_early: got %0d early cycles expected 0", early); end
    @(negedge clk);
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b expected 1", timeout); end
    checks++; if (m0_ready !== 1'b1 || m0_data_out !== 8'h00) begin errors++; $display("FAIL to_m0_pulse: got rdy=%b d=%h expected 1 00", m0_ready, m0_data_out); end
    checks++; if (mem_read_en !== 1'b0) begin errors++; $display("FAIL to_rd_drop: got %b expected 0", mem_read_en); end
    m0_read_en = 1'b0; stall = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (grant != 2'b00) found = 1'b1;
    end
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL to_next_grant: got %b expected 10", grant); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (m1_ready) found = 1'b1;
    end
    checks++; if (!found || m1_data_out !== 8'h5B) begin errors++; $display("FAIL to_m1_read: got seen=%0d d=%h expected 1 5b", found, m1_data_out); end
    m1_read_en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_then_read();
    test_overflow();
    test_abandon();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
